// File: rtl/parity_frame_pkg.sv
// Shared definitions for the serial parity frame controller: FSM state
// encoding and the parity error counter geometry.
package parity_frame_pkg;

    // Frame controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Parity error counter width and the value at which it saturates.
    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage : parity_frame_pkg

// File: rtl/parity_frame_ctrl_tracker.sv
// parity_tracker: one-bit running parity accumulator. clr restarts the
// accumulation for a new frame, en folds bit_in into the running value.
// Reset is synchronous and active-high, and reset wins over clr and en.
module parity_tracker (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic is_odd
);

    // Accumulate parity of accepted bits; clr has priority over en.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            is_odd <= 1'b0;
        end else if (clr) begin
            is_odd <= 1'b0;
        end else if (en) begin
            is_odd <= is_odd ^ bit_in;
        end
    end

endmodule : parity_tracker

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: receives a serial frame of DATA_BITS data bits followed
// by one parity bit over a valid/ready handshake, and reports a parity error
// with a one-cycle frame_done pulse.
//
// Optional build macro: PARITY_FRAME_ERR_CNT_EN adds err_clr / err_count, a
// saturating count of frames that completed with a parity error.
module parity_frame_ctrl
    import parity_frame_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         bit_valid,
    input  logic                         bit_in,
`ifdef PARITY_FRAME_ERR_CNT_EN
    input  logic                         err_clr,
    output logic [ERR_CNT_W-1:0]         err_count,
`endif
    output logic                         bit_ready,
    output logic                         busy,
    output logic [$clog2(DATA_BITS+1)-1:0] bit_idx,
    output logic                         running_odd,
    output logic                         frame_done,
    output logic                         parity_err
);

    localparam int                IDX_W    = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
    // Parity value (data + parity bit) that a correct frame must produce.
    localparam logic              PAR_EXP  = (ODD_PARITY != 0);

    state_t state_q;
    state_t state_d;
    logic   parity_err_q;

    // Handshake decode straight from the state register so it does not
    // depend on the combinational output block.
    logic in_bit_state;
    logic accept;
    logic accept_data;
    logic accept_parity;
    logic start_frame;

    assign in_bit_state  = (state_q == DATA) || (state_q == PARITY);
    // abort outranks a simultaneous bit, which is then dropped.
    assign accept        = in_bit_state && bit_valid && !abort;
    assign accept_data   = accept && (state_q == DATA);
    assign accept_parity = accept && (state_q == PARITY);
    assign start_frame   = (state_q == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d    = state_q;
        bit_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && (bit_idx == LAST_IDX)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data bit counter and registered parity verdict. Both hold after the
    // frame so the final values stay visible until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx      <= '0;
            parity_err_q <= 1'b0;
        end else begin
            if (start_frame) begin
                bit_idx <= '0;
            end else if (accept_data) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (accept_parity) begin
                parity_err_q <= ((running_odd ^ bit_in) != PAR_EXP);
            end
        end
    end

    // The verdict is only presented during the frame_done pulse.
    assign parity_err = frame_done && parity_err_q;

    parity_tracker u_tracker (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_frame),
        .en     (accept_data),
        .bit_in (bit_in),
        .is_odd (running_odd)
    );

`ifdef PARITY_FRAME_ERR_CNT_EN
    // Saturating count of bad frames; err_clr wins over an increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (parity_err && (err_count != ERR_CNT_MAX)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end
`endif

endmodule : parity_frame_ctrl

// File: tb/tb_parity_frame_ctrl.sv
// Testbench for parity_frame_ctrl (DATA_BITS=8, even parity). Stimulus
// pushes the expected frame result into a scoreboard queue when it sends
// the parity bit; a negedge monitor pops and compares on every frame_done.
// Counter checks are compiled when PARITY_FRAME_ERR_CNT_EN is defined.
module tb_parity_frame_ctrl;
    import parity_frame_pkg::*;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             busy;
    logic [IDX_W-1:0] bit_idx;
    logic             running_odd;
    logic             frame_done;
    logic             parity_err;
`ifdef PARITY_FRAME_ERR_CNT_EN
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_count;
`endif

    typedef struct {
        logic             perr;
        logic             odd;
        logic [IDX_W-1:0] idx;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;
    logic mon_en  = 1'b0;

    // Frame data 1,0,1,1,0,0,0,0 sent LSB first: three ones, odd.
    localparam logic [7:0] FRAME_D = 8'b0000_1101;

    parity_frame_ctrl #(
        .DATA_BITS  (DATA_BITS),
        .ODD_PARITY (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
`ifdef PARITY_FRAME_ERR_CNT_EN
        .err_clr     (err_clr),
        .err_count   (err_count),
`endif
        .bit_ready   (bit_ready),
        .busy        (busy),
        .bit_idx     (bit_idx),
        .running_odd (running_odd),
        .frame_done  (frame_done),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every frame_done must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_parity_err", 64'(parity_err), 64'(mon_e.perr));
                    check("done_running_odd", 64'(running_odd), 64'(mon_e.odd));
                    check("done_bit_idx", 64'(bit_idx), 64'(mon_e.idx));
                    check("done_latency", 64'(cyc_cnt), 64'(mon_e.cyc));
                end
            end else if (parity_err !== 1'b0) begin
                check("parity_err_outside_done", 64'(parity_err), 64'd0);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d, input int from, input int to);
        for (int i = from; i < to; i++) send_bit(d[i]);
    endtask

    task automatic send_parity(input logic b, input logic exp_err, input logic exp_odd);
        exp_t e;
        e.perr = exp_err;
        e.odd  = exp_odd;
        e.idx  = IDX_W'(DATA_BITS);
        e.cyc  = cyc_cnt + 1;
        sb.push_back(e);
        send_bit(b);
    endtask

    // Ends at the negedge inside the DONE cycle.
    task automatic run_frame(input logic [7:0] d, input logic par,
                             input logic exp_err, input logic exp_odd);
        do_start();
        send_data(d, 0, DATA_BITS);
        send_parity(par, exp_err, exp_odd);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bit_ready"}, 64'(bit_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
`ifdef PARITY_FRAME_ERR_CNT_EN
        err_clr   = 1'b0;
`endif
        tick(2);
        rst = 1'b0;

        // Power-on reset state.
        check_idle("reset");
        check("reset_bit_idx", 64'(bit_idx), 64'd0);
        check("reset_running_odd", 64'(running_odd), 64'd0);
        check("reset_parity_err", 64'(parity_err), 64'd0);
`ifdef PARITY_FRAME_ERR_CNT_EN
        check("reset_err_count", 64'(err_count), 64'd0);
`endif
        mon_en = 1'b1;

        // Good frame with step-by-step checks.
        do_start();
        check("data_bit_ready", 64'(bit_ready), 64'd1);
        check("data_bit_idx0", 64'(bit_idx), 64'd0);
        send_data(FRAME_D, 0, DATA_BITS);
        check("good_idx_after_data", 64'(bit_idx), 64'd8);
        check("good_odd_after_data", 64'(running_odd), 64'd1);
        check("parity_bit_ready", 64'(bit_ready), 64'd1);
        send_parity(1'b1, 1'b0, 1'b1);
        check("done_bit_ready", 64'(bit_ready), 64'd0);
        check("done_busy", 64'(busy), 64'd1);
        tick();
        check_idle("after_good");
        check("hold_bit_idx", 64'(bit_idx), 64'd8);
        check("hold_running_odd", 64'(running_odd), 64'd1);

        // Bad frame: wrong parity bit.
        run_frame(FRAME_D, 1'b0, 1'b1, 1'b1);
        tick();
`ifdef PARITY_FRAME_ERR_CNT_EN
        check("err_count_after_bad", 64'(err_count), 64'd1);
`endif

        // Stall after four data bits; garbage on bit_in must be ignored.
        do_start();
        send_data(FRAME_D, 0, 4);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b0;
            bit_in    = 1'b1;
            tick();
            check("stall_bit_idx", 64'(bit_idx), 64'd4);
            check("stall_running_odd", 64'(running_odd), 64'd1);
        end
        send_data(FRAME_D, 4, DATA_BITS);
        send_parity(1'b1, 1'b0, 1'b1);
        tick();

        // Abort with a simultaneous valid bit at bit_idx=3.
        do_start();
        send_data(FRAME_D, 0, 3);
        check("pre_abort_idx", 64'(bit_idx), 64'd3);
        check("pre_abort_odd", 64'(running_odd), 64'd0);
        abort     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        abort     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check_idle("abort");
        check("abort_idx_discard", 64'(bit_idx), 64'd3);
        check("abort_odd_discard", 64'(running_odd), 64'd0);
        tick(2);
        run_frame(FRAME_D, 1'b1, 1'b0, 1'b1);
        tick();

        // start mid-frame is ignored; start+abort in DONE are ignored.
        do_start();
        send_data(FRAME_D, 0, 2);
        start = 1'b1;
        send_bit(FRAME_D[2]);
        start = 1'b0;
        check("midframe_start_idx", 64'(bit_idx), 64'd3);
        send_data(FRAME_D, 3, DATA_BITS);
        send_parity(1'b1, 1'b0, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("done_start_ignored");
        tick();
        check("no_queued_start", 64'(busy), 64'd0);

        // Reset held two cycles mid-frame, beating start/abort/bit_valid.
        do_start();
        send_data(FRAME_D, 0, 3);
        rst       = 1'b1;
        start     = 1'b1;
        abort     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick(2);
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check_idle("midframe_reset");
        check("midframe_reset_idx", 64'(bit_idx), 64'd0);
        check("midframe_reset_odd", 64'(running_odd), 64'd0);
        tick(4);

`ifdef PARITY_FRAME_ERR_CNT_EN
        // Saturation, then err_clr racing a bad frame_done.
        for (int i = 0; i < 256; i++) begin
            run_frame(FRAME_D, 1'b0, 1'b1, 1'b1);
            tick();
        end
        check("err_count_saturated", 64'(err_count), 64'd255);
        run_frame(FRAME_D, 1'b0, 1'b1, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_beats_inc", 64'(err_count), 64'd0);
`endif

        tick(2);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_parity_frame_ctrl

// File: doc/parity_frame_ctrl.md
PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the data bits per frame; legal range 2..64.
REQ-002 Parameter ODD_PARITY, default 0, SHALL select the expected parity: 0 = even count of ones over data+parity, 1 = odd count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a frame; sampled only in IDLE.
REQ-006 abort  input  1  drop the current frame; return to IDLE.
REQ-007 bit_valid  input  1  bit_in is valid this cycle.
REQ-008 bit_in  input  1  serial bit, data bits first, then the parity bit.
REQ-009 bit_ready  output  1  controller accepts a bit this cycle.
REQ-010 busy  output  1  high in DATA, PARITY and DONE.
REQ-011 bit_idx  output  $clog2(DATA_BITS+1)  count of data bits accepted in the current frame.
REQ-012 running_odd  output  1  parity of the data bits accepted so far (1 = odd count of ones).
REQ-013 frame_done  output  1  one-cycle pulse at frame completion.
REQ-014 parity_err  output  1  parity check result; meaningful only while frame_done is high, 0 otherwise.

Function
REQ-015 The FSM SHALL have four states: IDLE, DATA, PARITY, DONE. A bit SHALL be accepted on any cycle where bit_valid and bit_ready are both high.
REQ-016 IDLE: bit_ready=0; on start, the FSM SHALL go to DATA next cycle and clear bit_idx and running_odd.
REQ-017 DATA: bit_ready=1; on acceptance, running_odd SHALL become running_odd^bit_in and bit_idx SHALL increment; the acceptance that makes bit_idx equal DATA_BITS SHALL move the FSM to PARITY.
REQ-018 PARITY: bit_ready=1; on acceptance, the FSM SHALL go to DONE and register parity_err = (running_odd^bit_in) != ODD_PARITY.
REQ-019 DONE: the FSM SHALL hold for exactly one cycle with frame_done=1 and bit_ready=0, then go to IDLE; bit_idx and running_odd SHALL hold their final values until the next start.
REQ-020 Latency: frame_done SHALL assert in the cycle after the parity bit is accepted.
REQ-021 Cycles with bit_valid=0 in DATA or PARITY SHALL stall the FSM with all state held; the FSM SHALL have no timeout.
REQ-022 start SHALL be ignored outside IDLE; a start in DONE SHALL NOT be queued.
REQ-023 abort in DATA or PARITY SHALL send the FSM to IDLE next cycle with no frame_done; abort SHALL beat a simultaneous bit acceptance, and that bit SHALL be discarded.
REQ-024 abort in IDLE or DONE SHALL have no effect; frame_done in DONE SHALL still pulse.
REQ-025 bit_in SHALL be ignored when bit_ready or bit_valid is low.

Reset
REQ-026 rst SHALL force IDLE, with bit_idx=0, running_odd=0, frame_done=0, parity_err=0, bit_ready=0 and busy=0 in the cycle after rst is sampled high.
REQ-027 rst SHALL beat start, abort and bit_valid in the same cycle, and a mid-frame rst SHALL discard the frame with no frame_done.

Configuration
REQ-028 Macro PARITY_FRAME_ERR_CNT_EN, when defined, SHALL add input err_clr (1 bit) and output err_count (8 bits, reset 0).
REQ-029 With the macro defined, err_count SHALL increment on each frame_done with parity_err=1 and saturate at 255.
REQ-030 With the macro defined, err_clr SHALL zero err_count and SHALL beat a simultaneous increment.
REQ-031 Without PARITY_FRAME_ERR_CNT_EN, these ports and the counter SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-032 Shared package parity_frame_pkg SHALL hold the state enum (IDLE, DATA, PARITY, DONE), the 8-bit counter width and the counter saturation constant.
REQ-033 Sub-module parity_tracker (clk, rst, clr, en, bit_in -> is_odd) SHALL hold running_odd; the controller SHALL drive its clr and en.

Verification
REQ-034 Reset: assert rst for 2 cycles during a frame -> next cycle IDLE, all outputs 0, and no frame_done thereafter.
REQ-035 Good frame, DATA_BITS=8, ODD_PARITY=0: start, then data 1,0,1,1,0,0,0,0 and parity 1 -> running_odd=1 after the data, frame_done one cycle after the parity bit, parity_err=0.
REQ-036 Bad frame: same data with parity 0 -> parity_err=1 on frame_done; with the macro, err_count=1.
REQ-037 Stall: insert 3 bit_valid=0 cycles after data bit 4 -> bit_idx holds at 4, and the result matches REQ-035.
REQ-038 Abort: abort together with bit_valid at bit_idx=3 -> IDLE next cycle, no frame_done, bit discarded; a following good frame passes.
REQ-039 Counter: 256 bad frames -> err_count=255, held; err_clr together with a bad frame_done -> err_count=0.
